// File: rtl/alu_pkg.sv
// ============================================================================
// Package     : alu_pkg
// Description : Shared opcode map and widths for the extended ALU operations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Native datapath width.
  parameter int DATA_W = 8;

  // Rotate amount width for the native datapath (log2 of DATA_W).
  localparam int SHAMT_W = 3;

  // SELECT encodings. These follow the basic ALU opcode map.
  localparam logic [2:0] OP_MULT = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_ext_mult8.sv
// ============================================================================
// Module      : alu_ext_mult8
// Description : Combinational shift-add array multiplier; returns the low
//               WIDTH bits of the unsigned product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ext_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);

  logic [WIDTH-1:0] w_acc;

  // Accumulate one shifted copy of i_a per set bit of i_b; carries beyond
  // WIDTH fall off, which is exactly the low-byte product.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_b[i]) begin
        w_acc = w_acc + (i_a << i);
      end
    end
  end

  assign o_p = w_acc;

endmodule : alu_ext_mult8

`default_nettype wire

// File: rtl/alu_ext_ops.sv
// ============================================================================
// Module      : alu_ext_ops
// Description : Registered extended-operation unit: unsigned multiply (low
//               bits), rotate right, arithmetic shift right. One-cycle
//               latency with a valid strobe.
//               Optional macro ALU_EXT_ZERO_FLAG_EN adds a registered ZERO
//               output that flags a 0 result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ext_ops
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  output logic [WIDTH-1:0] RESULT,
`ifdef ALU_EXT_ZERO_FLAG_EN
  output logic             ZERO,
`endif
  output logic             OUT_VALID
);

  // Rotate/shift amount width: the package value for the native width,
  // otherwise derived from WIDTH.
  localparam int c_SHAMT_W = (WIDTH == DATA_W) ? SHAMT_W :
                             ((WIDTH > 1) ? $clog2(WIDTH) : 1);
  localparam logic [WIDTH-1:0] c_WIDTH_V = WIDTH[WIDTH-1:0];

  logic [WIDTH-1:0]   w_mult;
  logic [c_SHAMT_W-1:0] w_amt;
  logic [2*WIDTH-1:0] w_ror_wide;
  logic [WIDTH-1:0]   w_ror;
  logic               w_sra_sat;
  logic [WIDTH-1:0]   w_sra;
  logic [WIDTH-1:0]   w_next;

  logic [WIDTH-1:0]   r_result;
  logic               r_valid;

  alu_ext_mult8 #(
    .WIDTH (WIDTH)
  ) u_mult (
    .i_a (DATA1),
    .i_b (DATA2),
    .o_p (w_mult)
  );

  // Low bits of DATA2 serve as the rotate amount (mod WIDTH) and as the
  // in-range arithmetic shift amount.
  assign w_amt = DATA2[c_SHAMT_W-1:0];

  // Rotate right: shift a doubled copy and keep the low half.
  assign w_ror_wide = {DATA1, DATA1} >> w_amt;
  assign w_ror      = w_ror_wide[WIDTH-1:0];

  // Arithmetic shift uses the full unsigned DATA2; any amount of WIDTH or
  // more saturates to the replicated sign bit.
  assign w_sra_sat = (DATA2 >= c_WIDTH_V);

  // Select sign-fill or the in-range arithmetic shift.
  always_comb begin
    w_sra = $signed(DATA1) >>> w_amt;
    if (w_sra_sat) begin
      w_sra = {WIDTH{DATA1[WIDTH-1]}};
    end
  end

  // Result mux; unsupported opcodes produce zero.
  always_comb begin
    w_next = '0;
    case (SELECT)
      OP_MULT: w_next = w_mult;
      OP_SRA:  w_next = w_sra;
      OP_ROR:  w_next = w_ror;
      default: w_next = '0;
    endcase
  end

  // Result register: reset clears, accepted ops load, idle cycles hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= IN_VALID;
      if (IN_VALID) begin
        r_result <= w_next;
      end
    end
  end

  assign RESULT    = r_result;
  assign OUT_VALID = r_valid;

`ifdef ALU_EXT_ZERO_FLAG_EN
  logic r_zero;

  // Zero flag tracks the result register: same reset, load and hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_zero <= 1'b0;
    end else if (IN_VALID) begin
      r_zero <= (w_next == '0);
    end
  end

  assign ZERO = r_zero;
`else
`endif

endmodule : alu_ext_ops

`default_nettype wire

// File: tb/tb_alu_ext_ops.sv
// ============================================================================
// Module      : tb_alu_ext_ops
// Description : Directed self-checking bench for alu_ext_ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ext_ops;

  logic       CLK;
  logic       RESET;
  logic       IN_VALID;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] SELECT;
  logic [7:0] RESULT;
  logic       OUT_VALID;
`ifdef ALU_EXT_ZERO_FLAG_EN
  logic       ZERO;
`endif

  int checks;
  int failures;

  alu_ext_ops #(
    .WIDTH (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .SELECT    (SELECT),
    .RESULT    (RESULT),
`ifdef ALU_EXT_ZERO_FLAG_EN
    .ZERO      (ZERO),
`endif
    .OUT_VALID (OUT_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reset held with live ops, then one idle cycle after release.
  task automatic test_reset();
    @(negedge CLK);
    RESET = 1'b1; IN_VALID = 1'b1; SELECT = 3'b100; DATA1 = 8'h0F; DATA2 = 8'h11;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (RESULT !== 8'h00 || OUT_VALID !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d: got RESULT=%h OUT_VALID=%b, want 00/0", c, RESULT, OUT_VALID);
      end
      @(negedge CLK);
      SELECT = 3'b111; DATA1 = 8'hA5; DATA2 = 8'h03;
    end
    RESET = 1'b0; IN_VALID = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (RESULT !== 8'h00 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got RESULT=%h OUT_VALID=%b, want 00/0", RESULT, OUT_VALID);
    end
  endtask

  task automatic test_mult();
    logic [7:0] a  [3] = '{8'h0F, 8'h10, 8'hFF};
    logic [7:0] b  [3] = '{8'h11, 8'h10, 8'hFF};
    logic [7:0] ex [3] = '{8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) begin
      // Idle cycle first so the valid strobe is seen to rise one cycle later.
      @(negedge CLK);
      IN_VALID = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (OUT_VALID !== 1'b0) begin
        failures++;
        $display("FAIL mult_idle %0d: got OUT_VALID=%b, want 0", i, OUT_VALID);
      end
      @(negedge CLK);
      IN_VALID = 1'b1; SELECT = 3'b100; DATA1 = a[i]; DATA2 = b[i];
      @(posedge CLK); #1;
      checks++;
      if (RESULT !== ex[i] || OUT_VALID !== 1'b1) begin
        failures++;
        $display("FAIL mult %h*%h: got RESULT=%h OUT_VALID=%b, want %h/1", a[i], b[i], RESULT, OUT_VALID, ex[i]);
      end
`ifdef ALU_EXT_ZERO_FLAG_EN
      checks++;
      if (ZERO !== (ex[i] == 8'h00)) begin
        failures++;
        $display("FAIL mult_zero %h*%h: got ZERO=%b, want %b", a[i], b[i], ZERO, (ex[i] == 8'h00));
      end
`endif
    end
  endtask

  task automatic test_ror();
    logic [7:0] a  [5] = '{8'h81, 8'h81, 8'hA5, 8'h01, 8'h01};
    logic [7:0] b  [5] = '{8'd1,  8'd9,  8'd0,  8'd7,  8'd1};
    logic [7:0] ex [5] = '{8'hC0, 8'hC0, 8'hA5, 8'h02, 8'h80};
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; SELECT = 3'b111; DATA1 = a[i]; DATA2 = b[i];
      @(posedge CLK); #1;
      checks++;
      if (RESULT !== ex[i] || OUT_VALID !== 1'b1) begin
        failures++;
        $display("FAIL ror %h by %0d: got RESULT=%h OUT_VALID=%b, want %h/1", a[i], b[i], RESULT, OUT_VALID, ex[i]);
      end
    end
  endtask

  task automatic test_sra();
    logic [7:0] a  [6] = '{8'h80, 8'h80, 8'h40, 8'h7F, 8'h80, 8'hC4};
    logic [7:0] b  [6] = '{8'd3,  8'd200, 8'd10, 8'd0, 8'd8, 8'd7};
    logic [7:0] ex [6] = '{8'hF0, 8'hFF, 8'h00, 8'h7F, 8'hFF, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; SELECT = 3'b110; DATA1 = a[i]; DATA2 = b[i];
      @(posedge CLK); #1;
      checks++;
      if (RESULT !== ex[i] || OUT_VALID !== 1'b1) begin
        failures++;
        $display("FAIL sra %h by %0d: got RESULT=%h OUT_VALID=%b, want %h/1", a[i], b[i], RESULT, OUT_VALID, ex[i]);
      end
    end
  endtask

  // Mixed ops on consecutive edges, then idle hold, unsupported opcodes,
  // and reset colliding with a valid op.
  task automatic test_back_to_back();
    logic [2:0] s  [5] = '{3'b100, 3'b111, 3'b110, 3'b001, 3'b101};
    logic [7:0] a  [5] = '{8'h03, 8'h0F, 8'hF0, 8'hFF, 8'h12};
    logic [7:0] b  [5] = '{8'h05, 8'h04, 8'h02, 8'hFF, 8'h34};
    logic [7:0] ex [5] = '{8'h0F, 8'hF0, 8'hFC, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; SELECT = s[i]; DATA1 = a[i]; DATA2 = b[i];
      @(posedge CLK); #1;
      checks++;
      if (RESULT !== ex[i] || OUT_VALID !== 1'b1) begin
        failures++;
        $display("FAIL b2b op%0d: got RESULT=%h OUT_VALID=%b, want %h/1", i, RESULT, OUT_VALID, ex[i]);
      end
    end
    @(negedge CLK);
    IN_VALID = 1'b0; SELECT = 3'b100; DATA1 = 8'h07; DATA2 = 8'h07;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (RESULT !== 8'hFC || OUT_VALID !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d: got RESULT=%h OUT_VALID=%b, want FC/0", c, RESULT, OUT_VALID);
      end
    end
    for (int i = 3; i < 5; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; SELECT = s[i]; DATA1 = a[i]; DATA2 = b[i];
      @(posedge CLK); #1;
      checks++;
      if (RESULT !== ex[i] || OUT_VALID !== 1'b1) begin
        failures++;
        $display("FAIL unsupported sel=%b: got RESULT=%h OUT_VALID=%b, want %h/1", s[i], RESULT, OUT_VALID, ex[i]);
      end
    end
    // Load a non-zero value, then collide reset with a valid op.
    @(negedge CLK);
    IN_VALID = 1'b1; SELECT = 3'b111; DATA1 = 8'h5A; DATA2 = 8'd0;
    @(posedge CLK); #1;
    checks++;
    if (RESULT !== 8'h5A || OUT_VALID !== 1'b1) begin
      failures++;
      $display("FAIL pre_collide: got RESULT=%h OUT_VALID=%b, want 5A/1", RESULT, OUT_VALID);
    end
    @(negedge CLK);
    RESET = 1'b1; SELECT = 3'b100; DATA1 = 8'h03; DATA2 = 8'h03;
    @(posedge CLK); #1;
    checks++;
    if (RESULT !== 8'h00 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins: got RESULT=%h OUT_VALID=%b, want 00/0", RESULT, OUT_VALID);
    end
    @(negedge CLK);
    RESET = 1'b0; IN_VALID = 1'b0;
  endtask

`ifdef ALU_EXT_ZERO_FLAG_EN
  task automatic test_zero_flag();
    @(negedge CLK);
    IN_VALID = 1'b1; SELECT = 3'b100; DATA1 = 8'h10; DATA2 = 8'h10;
    @(posedge CLK); #1;
    checks++;
    if (ZERO !== 1'b1 || RESULT !== 8'h00) begin
      failures++;
      $display("FAIL zero_set: got ZERO=%b RESULT=%h, want 1/00", ZERO, RESULT);
    end
    @(negedge CLK);
    SELECT = 3'b111; DATA1 = 8'h01; DATA2 = 8'h01;
    @(posedge CLK); #1;
    checks++;
    if (ZERO !== 1'b0 || RESULT !== 8'h80) begin
      failures++;
      $display("FAIL zero_clear: got ZERO=%b RESULT=%h, want 0/80", ZERO, RESULT);
    end
    @(negedge CLK);
    IN_VALID = 1'b0; SELECT = 3'b100; DATA1 = 8'h00; DATA2 = 8'h00;
    @(posedge CLK); #1;
    checks++;
    if (ZERO !== 1'b0 || RESULT !== 8'h80) begin
      failures++;
      $display("FAIL zero_hold: got ZERO=%b RESULT=%h, want 0/80", ZERO, RESULT);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b1;
    IN_VALID = 1'b0;
    SELECT   = 3'b000;
    DATA1    = 8'h00;
    DATA2    = 8'h00;
    test_reset();
    test_mult();
    test_ror();
    test_sra();
    test_back_to_back();
`ifdef ALU_EXT_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_ext_ops

`default_nettype wire
